// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the parametrised synchronous FIFO.
//   clog2()      - ceiling log2, usable in constant expressions
//   ptr_width()  - read/write pointer width for a given depth
//   cnt_width()  - occupancy counter width (must represent 0..depth)
//   DEFAULT_*    - default geometry and almost-flag thresholds
//   head_src_e   - source of the FWFT output word (RAM read register or bypass)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_DEPTH     = 1024;
    localparam int DEFAULT_AE_THRESH = 4;
    // almost_full defaults to DEPTH minus this margin
    localparam int DEFAULT_AF_MARGIN = 4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2(depth);
    endfunction

    // One extra bit so that count == depth is representable.
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEPTH);

    typedef enum logic {
        HEAD_RAM = 1'b0,
        HEAD_BYP = 1'b1
    } head_src_e;

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port memory, WIDTH x DEPTH, one clock.
//   clk      in   clock, rising edge
//   rst      in   async active-high reset (clears the read data register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data loads mem[rd_addr] at the edge
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds when rd_en is low
// A read and a write to the same address on the same edge return the old word.
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Storage array has no reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow flags.
//
// Build option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through
// output. Without it, rData is valid the cycle after an accepted read.
//
// Ports
//   clk           in   clock, rising edge
//   arst          in   async active-high reset
//   wEn / wData   in   write request / data
//   rEn           in   read request (FWFT: pop the presented word)
//   rData         out  read data
//   err_clr       in   sync clear of overflow/underflow (a new error wins)
//   full, empty   out  count == DEPTH, count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky, a write was dropped
//   underflow     out  sticky, a read was dropped
// All flags decode the registered count only.
// -----------------------------------------------------------------------------
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - DEFAULT_AF_MARGIN,
    parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        wEn,
    input  logic [WIDTH-1:0]            wData,
    input  logic                        rEn,
    output logic [WIDTH-1:0]            rData,
    input  logic                        err_clr,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_acc;
    logic             wr_acc;
    logic             ram_we;
    logic             ram_re;
    logic [WIDTH-1:0] ram_rdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept rules, count and sticky errors are common to both modes.
    always_comb begin
        rd_acc = rEn & ~empty;
        // A write at full is still taken when a read frees a slot this edge.
        wr_acc = wEn & (~full | rd_acc);

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - 1'b1;
        end

        overflow_d = overflow_q;
        if (wEn && !wr_acc) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (rEn && !rd_acc) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // The presented word lives either in the RAM read register or in a bypass
    // register. Whenever count > 0 the head slot is occupied, so the RAM holds
    // count-1 words and never more than DEPTH-1; read and write addresses can
    // therefore never collide on the same edge.
    head_src_e        head_src_q, head_src_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;
    logic             need_head;
    logic             ram_has_data;
    logic             byp_load;

    always_comb begin
        need_head    = empty | rd_acc;
        ram_has_data = (count_q > CW'(1));
        ram_re       = need_head & ram_has_data;
        // Nothing queued behind the head: the incoming word goes straight out.
        byp_load     = need_head & ~ram_has_data & wr_acc;
        ram_we       = wr_acc & ~byp_load;

        wr_ptr_d = wr_ptr_q;
        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (ram_re) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        head_src_d = head_src_q;
        byp_data_d = byp_data_q;
        if (ram_re) begin
            head_src_d = HEAD_RAM;
        end else if (byp_load) begin
            head_src_d = HEAD_BYP;
            byp_data_d = wData;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            head_src_q <= HEAD_BYP;
            byp_data_q <= '0;
        end else begin
            head_src_q <= head_src_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign rData = (head_src_q == HEAD_BYP) ? byp_data_q : ram_rdata;
`else
    always_comb begin
        ram_we = wr_acc;
        ram_re = rd_acc;

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // At full with read+write the addresses coincide; the RAM returns the
    // old word, which is the one being popped.
    assign rData = ram_rdata;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .rst     (arst),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wData),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = 4;
    localparam int AE = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          wEn;
    logic [W-1:0]  wData;
    logic          rEn;
    logic [W-1:0]  rData;
    logic          err_clr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .wEn          (wEn),
        .wData        (wData),
        .rEn          (rEn),
        .rData        (rData),
        .err_clr      (err_clr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue of words plus the sticky bits.
    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_unf;
    logic [W-1:0] m_rdata;

    typedef struct {
        logic          wen;
        logic [W-1:0]  wd;
        logic          ren;
        logic          clr;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          unf;
        logic          chk_rd;
        logic [W-1:0]  rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wen, input logic [W-1:0] wd, input logic ren,
                                input logic clr, input int cnt, input logic ovf,
                                input logic unf, input logic chk_rd, input logic [W-1:0] rd);
        vec_t v;
        v.wen = wen; v.wd = wd; v.ren = ren; v.clr = clr;
        v.cnt = CW'(cnt); v.ovf = ovf; v.unf = unf; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic model_step(input logic wen, input logic [W-1:0] wd, input logic ren, input logic clr);
        bit rd_ok;
        bit wr_ok;
        logic [W-1:0] popped;
        rd_ok = ren && (mq.size() > 0);
        wr_ok = wen && ((mq.size() < D) || rd_ok);
        if (rd_ok) begin
            popped  = mq.pop_front();
            m_rdata = popped;
        end
        if (wr_ok) mq.push_back(wd);
        if (wen && !wr_ok) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (ren && !rd_ok) m_unf = 1'b1;
        else if (clr)      m_unf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},        32'(count),        32'(mq.size()));
        chk({tag, ".empty"},        32'(empty),        32'(mq.size() == 0));
        chk({tag, ".full"},         32'(full),         32'(mq.size() == D));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(mq.size() >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mq.size() <= AE));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        if (mq.size() > 0) chk({tag, ".rData_head"}, 32'(rData), 32'(mq[0]));
`else
        chk({tag, ".rData"}, 32'(rData), 32'(m_rdata));
`endif
    endtask

    task automatic cycle(input string tag, input logic wen, input logic [W-1:0] wd,
                         input logic ren, input logic clr);
        wEn     = wen;
        wData   = wd;
        rEn     = ren;
        err_clr = clr;
        @(posedge clk);
        #1;
        model_step(wen, wd, ren, clr);
        check_model(tag);
    endtask

    task automatic idle_inputs();
        wEn = 1'b0; wData = '0; rEn = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        arst = 1'b1;
        model_reset();
        #2;
        check_model("reset");
        @(posedge clk);
        #1;
        arst = 1'b0;
        cycle("idle0", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("idle1", 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, overflow, error clear, full pass-through, drain, empty corner cases.
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1, 8'(i), 0, 0, i, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h99, 0, 0, 8, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 0, 1, 8, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h9A, 0, 1, 8, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 0, 1, 8, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'hA0, 1, 0, 8, 0, 0, 1, 8'h01));
        tbl.push_back(mk(1, 8'hA1, 1, 0, 8, 0, 0, 1, 8'h02));
        tbl.push_back(mk(1, 8'hA2, 1, 0, 8, 0, 0, 1, 8'h03));
        tbl.push_back(mk(0, 8'h00, 1, 0, 7, 0, 0, 1, 8'h04));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6, 0, 0, 1, 8'h05));
        tbl.push_back(mk(0, 8'h00, 1, 0, 5, 0, 0, 1, 8'h06));
        tbl.push_back(mk(0, 8'h00, 1, 0, 4, 0, 0, 1, 8'h07));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3, 0, 0, 1, 8'h08));
        tbl.push_back(mk(0, 8'h00, 1, 0, 2, 0, 0, 1, 8'hA0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hA1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hA2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'hA2));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h55, 1, 0, 1, 0, 1, 1, 8'hA2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));

        foreach (tbl[i]) begin
            cycle($sformatf("vec%0d", i), tbl[i].wen, tbl[i].wd, tbl[i].ren, tbl[i].clr);
            chk($sformatf("vec%0d.count_tbl", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.ovf_tbl", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d.unf_tbl", i), 32'(underflow), 32'(tbl[i].unf));
`ifndef PARAM_SYNC_FIFO_FWFT_EN
            if (tbl[i].chk_rd) chk($sformatf("vec%0d.rData_tbl", i), 32'(rData), 32'(tbl[i].rd));
`endif
        end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
        // Write into empty falls through without any read request.
        cycle("fwft_w", 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("fwft.rData", 32'(rData), 32'h3C);
        chk("fwft.empty", 32'(empty), 32'h0);
        cycle("fwft_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fwft.rData_hold", 32'(rData), 32'h3C);
        cycle("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);
`endif

        // Reset asserted mid-burst, away from any clock edge.
        cycle("burst0", 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("burst1", 1'b1, 8'h22, 1'b1, 1'b0);
        cycle("burst2", 1'b1, 8'h33, 1'b0, 1'b0);
        cycle("burst3", 1'b1, 8'h44, 1'b1, 1'b0);
        cycle("burst4", 1'b1, 8'h00, 1'b1, 1'b0);
        #2;
        arst = 1'b1;
        #1;
        model_reset();
        check_model("midreset");
        chk("midreset.rData", 32'(rData), 32'h0);
        idle_inputs();
        @(posedge clk);
        #1;
        arst = 1'b0;
        cycle("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic: a filling phase, then the nominal 25%/50% mix.
        for (int i = 0; i < 3000; i++)
            cycle("rnd_fill", ($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 40),
                  ($urandom_range(99) < 2));
        for (int i = 0; i < 3000; i++)
            cycle("rnd_mix", ($urandom_range(99) < 25), 8'($urandom), ($urandom_range(99) < 50),
                  ($urandom_range(99) < 2));

        for (int i = 0; i < 2 * D && mq.size() > 0; i++)
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.count_final", 32'(count), 32'h0);
        chk("drain.empty_final", 32'(empty), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
